// File: rtl/vga_charmem_ctrl.sv
// Port-A controller for the VGA character memory.
// Arbitrates CPU accesses against a one-row scroll engine.
module vga_charmem_ctrl #(
   parameter int          COLS      = 80,
   parameter int          ROWS      = 30,
   parameter logic [7:0]  FILL_CHAR = 8'h20
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [11:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic        cpu_ack,
   output logic [7:0]  cpu_rdata,
   input  logic        scroll_start,
   output logic        scroll_busy,
   output logic        scroll_done,
   output logic [11:0] mem_addr,
   output logic        mem_we,
   output logic [7:0]  mem_din,
   input  logic [7:0]  mem_dout
);

   localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
   localparam logic [6:0] LAST_COL = 7'(COLS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WR,
      S_CLR,
      S_DONE
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic [4:0]  row;
   logic [4:0]  row_nx;
   logic [4:0]  row_m1;
   logic [6:0]  col;
   logic [6:0]  col_nx;
   logic        rd_pend;
   logic        eng_rd;
   logic [7:0]  hold_reg;
   logic [11:0] addr_q;
   logic        grant;

   // Engine may only use the port when the CPU leaves it free.
   assign grant     = !cpu_req;
   assign row_m1    = row - 5'd1;
   assign cpu_rdata = mem_dout;

   // Busy covers every state that can still issue an access.
   assign scroll_busy = (state == S_RD) ||
                        (state == S_WR) ||
                        (state == S_CLR);
   assign scroll_done = (state == S_DONE);

   // Next state, counters and the combinational port-A drive.
   always_comb begin
      state_nx = state;
      row_nx   = row;
      col_nx   = col;
      eng_rd   = 1'b0;
      mem_addr = addr_q;
      mem_we   = 1'b0;
      mem_din  = 8'h00;
      if (cpu_req) begin
         mem_addr = cpu_addr;
         mem_we   = cpu_we;
         mem_din  = cpu_wdata;
      end
      unique case (state)
         S_IDLE: begin
            if (scroll_start) begin
               row_nx   = 5'd1;
               col_nx   = 7'd0;
               state_nx = S_RD;
            end
         end
         S_RD: begin
            if (grant) begin
               mem_addr = {row, col};
               eng_rd   = 1'b1;
               state_nx = S_WR;
            end
         end
         S_WR: begin
            if (grant) begin
               mem_addr = {row_m1, col};
               mem_we   = 1'b1;
               // Data arrives from memory only now when WR
               // directly follows its RD.
               mem_din  = rd_pend ? mem_dout : hold_reg;
               if (col == LAST_COL) begin
                  col_nx = 7'd0;
                  if (row == LAST_ROW) begin
                     state_nx = S_CLR;
                  end else begin
                     row_nx   = row + 5'd1;
                     state_nx = S_RD;
                  end
               end else begin
                  col_nx   = col + 7'd1;
                  state_nx = S_RD;
               end
            end
         end
         S_CLR: begin
            if (grant) begin
               mem_addr = {LAST_ROW, col};
               mem_we   = 1'b1;
               mem_din  = FILL_CHAR;
               if (col == LAST_COL) begin
                  state_nx = S_DONE;
               end else begin
                  col_nx = col + 7'd1;
               end
            end
         end
         S_DONE: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // Engine state and counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         row   <= 5'd0;
         col   <= 7'd0;
      end else begin
         state <= state_nx;
         row   <= row_nx;
         col   <= col_nx;
      end
   end

   // Capture read data so a CPU access between RD and WR
   // cannot clobber it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pend  <= 1'b0;
         hold_reg <= 8'h00;
      end else begin
         rd_pend <= eng_rd;
         if (rd_pend) begin
            hold_reg <= mem_dout;
         end
      end
   end

   // Idle cycles keep presenting the last address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= 12'h000;
      end else begin
         addr_q <= mem_addr;
      end
   end

   // Every CPU request is acknowledged one cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cpu_ack <= 1'b0;
      end else begin
         cpu_ack <= cpu_req;
      end
   end

endmodule

// File: tb/tb_vga_charmem_ctrl.sv
// Bench for vga_charmem_ctrl with a 4096x8 port-A memory model.
// Checks CPU vectors and scroll results against a row-shift model.
module tb_vga_charmem_ctrl;

   localparam int COLS = 80;
   localparam int ROWS = 30;
   localparam logic [7:0] FILL = 8'h20;
   localparam int BUSY_NOM = (ROWS - 1) * COLS * 2 + COLS;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_req;
   logic        cpu_we;
   logic [11:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_ack;
   logic [7:0]  cpu_rdata;
   logic        scroll_start;
   logic        scroll_busy;
   logic        scroll_done;
   logic [11:0] mem_addr;
   logic        mem_we;
   logic [7:0]  mem_din;
   logic [7:0]  mem_dout;

   logic [7:0] mem [4096];
   logic [7:0] exp_mem [4096];
   logic       preload;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   vga_charmem_ctrl #(
      .COLS(COLS),
      .ROWS(ROWS),
      .FILL_CHAR(FILL)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .cpu_req(cpu_req),
      .cpu_we(cpu_we),
      .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack),
      .cpu_rdata(cpu_rdata),
      .scroll_start(scroll_start),
      .scroll_busy(scroll_busy),
      .scroll_done(scroll_done),
      .mem_addr(mem_addr),
      .mem_we(mem_we),
      .mem_din(mem_din),
      .mem_dout(mem_dout)
   );

   function automatic logic [7:0] pat(input int a);
      return 8'(((a >> 7) * 3) + (a & 127));
   endfunction

   // Synchronous memory, read-before-write, 1-cycle read latency.
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 4096; i++) mem[i] <= pat(i);
      end else if (mem_we) begin
         mem[mem_addr] <= mem_din;
      end
      mem_dout <= mem[mem_addr];
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_preload();
      @(negedge clk);
      preload = 1'b1;
      for (int i = 0; i < 4096; i++) exp_mem[i] = pat(i);
      @(negedge clk);
      preload = 1'b0;
   endtask

   // Model of one completed scroll: shift visible rows up, blank last.
   task automatic model_scroll();
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            if (r < ROWS - 1) exp_mem[r * 128 + c] = exp_mem[(r + 1) * 128 + c];
            else exp_mem[r * 128 + c] = FILL;
         end
      end
   endtask

   task automatic cmp_mem(input string nm);
      int bad = 0;
      int first = -1;
      for (int i = 0; i < 4096; i++) begin
         if (mem[i] !== exp_mem[i]) begin
            bad++;
            if (first < 0) first = i;
         end
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL %s: %0d cells wrong, first @%03h got %0h expected %0h",
                  nm, bad, first, mem[first], exp_mem[first]);
      end
   endtask

   // mode 0 plain, 1 random CPU reads, 2 preempt after RD,
   // 3 extra start while busy, 4 reset mid-scroll.
   task automatic run_scroll(input int mode, input int n_req,
                             output int bcnt, output int dcnt,
                             output int extra, output int ackerr,
                             output int seqerr, output bit finished);
      bit pend = 0;
      bit pend_rd = 0;
      logic [7:0] pend_exp = 8'h00;
      bit after_rd = 0;
      bit last_busy = 0;
      int issued = 0;
      int post = -1;
      int wcnt = 0;
      bcnt = 0; dcnt = 0; extra = 0; ackerr = 0; seqerr = 0;
      finished = 0;
      @(negedge clk);
      scroll_start = 1'b1;
      cpu_req = 1'b0;
      if (mode == 1) begin
         cpu_req = 1'b1;
         cpu_we = 1'b0;
         cpu_addr = 12'hFFF;
         pend = 1; pend_rd = 1;
         pend_exp = exp_mem[12'hFFF];
      end
      for (int cyc = 0; cyc < 20000; cyc++) begin
         @(negedge clk);
         scroll_start = 1'b0;
         if (pend) begin
            if (cpu_ack !== 1'b1 || (pend_rd && cpu_rdata !== pend_exp)) begin
               if (ackerr == 0)
                  $display("FAIL ack: ack=%b rdata=%0h expected rdata %0h",
                           cpu_ack, cpu_rdata, pend_exp);
               ackerr++;
            end
         end else if (cpu_ack !== 1'b0) begin
            ackerr++;
         end
         pend = 0;
         cpu_req = 1'b0;
         if (scroll_busy) bcnt++;
         if (scroll_done) dcnt++;
         if (scroll_done && !(last_busy && !scroll_busy)) seqerr++;
         last_busy = scroll_busy;
         if (post >= 0) post++;
         else if (scroll_done) post = 0;
         if (post >= 4) begin
            finished = 1;
            break;
         end
         if (mode == 3 && scroll_busy && bcnt == 100) scroll_start = 1'b1;
         if (mode == 4 && scroll_busy && bcnt == 2000) begin
            rst_n = 1'b0;
            #1;
            chk("rst_async_busy", {31'd0, scroll_busy}, 32'd0);
            chk("rst_async_done", {31'd0, scroll_done}, 32'd0);
            repeat (3) begin
               @(negedge clk);
               if (scroll_done) dcnt++;
            end
            rst_n = 1'b1;
            finished = 1;
            break;
         end
         if (mode == 1 && scroll_busy && issued < n_req &&
             $urandom_range(0, 3) == 0) begin
            cpu_req = 1'b1;
            cpu_we = 1'b0;
            cpu_addr = 12'hFFF;
            pend = 1; pend_rd = 1;
            pend_exp = exp_mem[12'hFFF];
            issued++;
            extra++;
         end
         if (mode == 2 && after_rd) begin
            cpu_req = 1'b1;
            cpu_we = 1'b1;
            cpu_addr = 12'hF7F;
            cpu_wdata = 8'(wcnt);
            exp_mem[12'hF7F] = 8'(wcnt);
            wcnt++;
            pend = 1; pend_rd = 0;
            extra++;
         end
         after_rd = 0;
         if (mode == 2) begin
            #1;
            if (!cpu_req && scroll_busy && !mem_we) after_rd = 1;
         end
      end
      cpu_req = 1'b0;
   endtask

   typedef struct {
      logic        we;
      logic [11:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  exp;
   } vec_t;

   vec_t vt [9];

   initial begin
      int bc, dc, ex, ae, se;
      bit fin;
      vt[0] = '{1'b1, 12'h085, 8'h41, 8'h00};
      vt[1] = '{1'b0, 12'h085, 8'h00, 8'h41};
      vt[2] = '{1'b1, 12'h000, 8'hFF, 8'h00};
      vt[3] = '{1'b1, 12'hFFF, 8'h5A, 8'h00};
      vt[4] = '{1'b0, 12'h000, 8'h00, 8'hFF};
      vt[5] = '{1'b0, 12'hFFF, 8'h00, 8'h5A};
      vt[6] = '{1'b1, 12'h7CF, 8'h3C, 8'h00};
      vt[7] = '{1'b0, 12'h7CF, 8'h00, 8'h3C};
      vt[8] = '{1'b0, 12'h085, 8'h00, 8'h41};

      rst_n = 1'b0;
      preload = 1'b0;
      cpu_req = 1'b0;
      cpu_we = 1'b0;
      cpu_addr = 12'h000;
      cpu_wdata = 8'h00;
      scroll_start = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_mem_addr", {20'd0, mem_addr}, 32'd0);
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rst_mem_din", {24'd0, mem_din}, 32'd0);
      chk("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
      chk("rst_busy", {31'd0, scroll_busy}, 32'd0);
      chk("rst_done", {31'd0, scroll_done}, 32'd0);
      rst_n = 1'b1;

      // Back-to-back CPU vectors: each check sees the previous request.
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         if (i > 0) begin
            chk($sformatf("vec%0d_ack", i - 1), {31'd0, cpu_ack}, 32'd1);
            if (!vt[i - 1].we)
               chk($sformatf("vec%0d_rdata", i - 1), {24'd0, cpu_rdata},
                   {24'd0, vt[i - 1].exp});
         end
         cpu_req = 1'b1;
         cpu_we = vt[i].we;
         cpu_addr = vt[i].addr;
         cpu_wdata = vt[i].wdata;
      end
      @(negedge clk);
      chk("vec8_ack", {31'd0, cpu_ack}, 32'd1);
      chk("vec8_rdata", {24'd0, cpu_rdata}, {24'd0, vt[8].exp});
      cpu_req = 1'b0;
      #1;
      chk("idle_addr_hold", {20'd0, mem_addr}, 32'h085);
      chk("idle_we", {31'd0, mem_we}, 32'd0);
      chk("idle_din", {24'd0, mem_din}, 32'd0);
      @(negedge clk);
      chk("idle_ack", {31'd0, cpu_ack}, 32'd0);

      do_preload();
      run_scroll(0, 0, bc, dc, ex, ae, se, fin);
      chk("plain_end", {31'd0, fin}, 32'd1);
      chk("plain_busy", bc, BUSY_NOM);
      chk("plain_done", dc, 1);
      chk("plain_seq", se, 0);
      model_scroll();
      cmp_mem("plain_mem");

      do_preload();
      run_scroll(1, 500, bc, dc, ex, ae, se, fin);
      chk("cont_end", {31'd0, fin}, 32'd1);
      chk("cont_busy", bc, BUSY_NOM + ex);
      chk("cont_done", dc, 1);
      chk("cont_ack", ae, 0);
      model_scroll();
      cmp_mem("cont_mem");

      do_preload();
      run_scroll(2, 0, bc, dc, ex, ae, se, fin);
      chk("pre_end", {31'd0, fin}, 32'd1);
      chk("pre_busy", bc, BUSY_NOM + ex);
      chk("pre_done", dc, 1);
      chk("pre_ack", ae, 0);
      model_scroll();
      cmp_mem("pre_mem");

      do_preload();
      run_scroll(3, 0, bc, dc, ex, ae, se, fin);
      chk("sbusy_end", {31'd0, fin}, 32'd1);
      chk("sbusy_busy", bc, BUSY_NOM);
      chk("sbusy_done", dc, 1);
      model_scroll();
      cmp_mem("sbusy_mem");

      do_preload();
      run_scroll(4, 0, bc, dc, ex, ae, se, fin);
      chk("abort_done", dc, 0);
      repeat (2) @(negedge clk);
      chk("abort_idle_busy", {31'd0, scroll_busy}, 32'd0);
      do_preload();
      run_scroll(0, 0, bc, dc, ex, ae, se, fin);
      chk("after_rst_end", {31'd0, fin}, 32'd1);
      chk("after_rst_busy", bc, BUSY_NOM);
      chk("after_rst_done", dc, 1);
      model_scroll();
      cmp_mem("after_rst_mem");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/vga_charmem_ctrl.md
# vga_charmem_ctrl

Port-A controller for the 4096×8 dual-port character memory behind the VGA text display. Arbitrates the memory's read/write port between the processor's I/O bus and an internal scroll engine. The scroll engine moves every text row up by one and fills the bottom row with a blank character. Port B, the display refresh read, is not touched by this block.

## Interface
Parameters:
- COLS, 80, visible columns per row (≤128)
- ROWS, 30, visible rows (≤32, ≥2)
- FILL_CHAR, 8'h20, byte written into the vacated bottom row

Ports:
- clk  in  1  system clock; the memory's port A uses the same clock
- rst_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  single-cycle request pulse from the I/O bus
- cpu_we  in  1  1 = write, 0 = read; qualified by cpu_req
- cpu_addr  in  12  {row[4:0], col[6:0]}
- cpu_wdata  in  8  write data
- cpu_ack  out  1  pulses one cycle after every cpu_req
- cpu_rdata  out  8  equals mem_dout; valid only while cpu_ack=1 for a read
- scroll_start  in  1  pulse that requests one scroll
- scroll_busy  out  1  high while the scroll engine is active
- scroll_done  out  1  one-cycle pulse when a scroll completes
- mem_addr  out  12  memory port-A address
- mem_we  out  1  memory port-A write enable
- mem_din  out  8  memory port-A write data
- mem_dout  in  8  memory port-A read data; registered, 1-cycle read latency

## Operation
- Address format is always {row, col}, so the address is row*128 + col.
- **Arbitration:** the CPU has absolute priority.
  - A cpu_req cycle always drives mem_* from the cpu_* inputs.
  - The engine issues an access only in cycles where cpu_req=0. Otherwise it holds its state and counters.
- **Idle port:** with no access in a cycle, mem_we=0, mem_din=0, and mem_addr holds its last value.
- **Engine states:** IDLE, RD, WR, CLR, DONE. Counters are row (5 bits) and col (7 bits).
- **IDLE:** on scroll_start, set row=1 and col=0, then go to RD.
- **RD (when granted):** read {row, col}, set rd_pend, go to WR.
- **Read capture:** hold_reg captures mem_dout in the cycle after any granted engine read, whether or not the engine is granted in that cycle. This protects the data from a CPU access that lands between RD and WR.
- **WR (when granted):**
  - Write hold_reg to {row-1, col}.
  - WR is never granted in the cycle immediately after RD unless hold_reg is bypassed with mem_dout. The implementation bypasses for that cycle; the data is the same.
  - Then step the counters: if col=COLS-1, set col=0 and row=row+1, otherwise col=col+1.
  - If the write just done was at row=ROWS-1 and col=COLS-1, set row=ROWS-1 and col=0 and go to CLR. Otherwise go to RD.
- **CLR (when granted):** write FILL_CHAR to {ROWS-1, col}. After col=COLS-1, go to DONE; otherwise col=col+1.
- **DONE:** scroll_done=1 for one cycle, then go to IDLE.
- **Start while busy:** scroll_start is ignored in any state other than IDLE.
- **Coincident requests:** scroll_start and cpu_req in the same cycle are both honoured. The CPU access happens now; the engine leaves IDLE and its first read waits for a free cycle.
- **Unused addresses:** columns COLS..127 and rows ROWS..31 are never touched by the engine.

## Timing
- **Reset values:** state=IDLE, row=0, col=0, rd_pend=0, hold_reg=0, mem_addr=0, mem_we=0, mem_din=0, cpu_ack=0, scroll_busy=0, scroll_done=0.
- **Reset mid-scroll:** the engine aborts immediately with no done pulse. Memory is left partially scrolled; this is accepted.
- **CPU latency:**
  - A cpu_req sampled at edge k produces cpu_ack=1 in cycle k+1.
  - For a read, cpu_rdata holds the data for that address in cycle k+1.
  - Back-to-back req pulses give back-to-back acks.
- **mem_* outputs** are combinational from the current state and cpu_* inputs. Memory sees the access at the following edge.
- **scroll_busy:** high from the cycle after scroll_start is accepted through the last CLR write cycle. It is 0 in DONE.
- **Uncontended duration:** busy lasts (ROWS-1)*COLS*2 + COLS cycles. For the defaults that is 4720 cycles, and scroll_done follows in the next cycle.
- **Contention:** every cpu_req cycle during busy extends busy by exactly one cycle.

## Test plan
- **Reset:** hold rst_n=0 and check every output at its reset value. Release, then pulse cpu_req with we=1, addr=12'h085, wdata=8'h41. Pulse a read of 12'h085 → cpu_ack in the next cycle with cpu_rdata=8'h41.
- **Uncontended scroll:**
  - Preload each cell so row r, col c holds (r*3+c) mod 256. Pulse scroll_start.
  - busy stays high for exactly 4720 cycles, then scroll_done pulses once.
  - Afterwards, row r holds the old row r+1 for r<29, row 29 holds 8'h20, and cols 80..127 are unchanged.
- **Contended scroll:** repeat the previous scroll with cpu_req reads of 12'hFFF on 500 random cycles → identical memory result, busy lasting 5220 cycles, and every read acked with the correct data.
- **Read-to-write preemption:** force cpu_req writes (addr 12'hF7F, cols ≥80) in the cycle right after each engine RD → scrolled data is still correct, proving the hold_reg capture works.
- **Start while busy:** pulse scroll_start at cycle 100 of a scroll → only one scroll happens, with one done pulse and one-row displacement.
- **Reset mid-scroll:** assert rst_n=0 at cycle 2000 → busy=0 asynchronously and no done pulse. After release, a new scroll_start completes normally in 4720 cycles.
